// File: rtl/mod_seq_checker.sv
// Sequence checker for the skip-a-number mod counter.
// Tracks the expected counter value, locks after LOCK_N consecutive correct
// steps, and reports sequence errors, illegal values and wraps. It also keeps
// a saturating count of sequence errors.
module mod_seq_checker #(
  parameter int LENGTH = 4,
  parameter int MAX    = 7,
  parameter int SKIP   = 3,
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LENGTH-1:0] count_in,
  input  logic              count_vld,
  output logic              locked_o,
  output logic              err_o,
  output logic              ill_o,
  output logic              wrap_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [LENGTH-1:0] exp_o
);

  localparam int HITS_W = $clog2(LOCK_N + 1);
  localparam logic [LENGTH-1:0] MAX_V    = LENGTH'(MAX);
  localparam logic [LENGTH-1:0] SKIP_V   = LENGTH'(SKIP);
  localparam logic [HITS_W-1:0] LOCK_N_V = HITS_W'(LOCK_N);
  localparam logic [ERR_W-1:0]  ERR_FULL = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t              r_state, w_stateNext;
  logic [LENGTH-1:0]   r_exp, w_expNext;
  logic [HITS_W-1:0]   r_hits, w_hitsNext;
  logic [ERR_W-1:0]    r_errCnt, w_errCntNext;
  logic                r_err, w_err;
  logic                r_ill, w_ill;
  logic                r_wrap, w_wrap;

  logic                w_legal;
  logic                w_match;
  logic [LENGTH-1:0]   w_next;
  logic [HITS_W-1:0]   w_hitsInc;

  // Successor of a legal counter value: MAX wraps to 0 and SKIP is jumped over.
  function automatic logic [LENGTH-1:0] nextVal(input logic [LENGTH-1:0] v);
    logic [LENGTH-1:0] plusOne;
    plusOne = v + LENGTH'(1);
    if (v == MAX_V)
      return '0;
    else if (plusOne == SKIP_V)
      return v + LENGTH'(2);
    else
      return plusOne;
  endfunction

  assign w_legal   = (count_in <= MAX_V) && (count_in != SKIP_V);
  assign w_match   = (count_in == r_exp);
  assign w_next    = nextVal(count_in);
  assign w_hitsInc = r_hits + HITS_W'(1);

  // Next-state, next-expected value and pulse decode for the current sample.
  always_comb begin
    w_stateNext  = r_state;
    w_expNext    = r_exp;
    w_hitsNext   = r_hits;
    w_errCntNext = r_errCnt;
    w_err        = 1'b0;
    w_ill        = 1'b0;
    w_wrap       = 1'b0;

    if (count_vld) begin
      unique case (r_state)
        IDLE: begin
          if (w_legal) begin
            w_stateNext = ACQ;
            w_expNext   = w_next;
            w_hitsNext  = '0;
          end else begin
            w_ill = 1'b1;
          end
        end
        ACQ: begin
          if (!w_legal) begin
            w_stateNext = IDLE;
            w_hitsNext  = '0;
            w_ill       = 1'b1;
          end else if (w_match) begin
            w_expNext  = w_next;
            w_hitsNext = w_hitsInc;
            if (w_hitsInc == LOCK_N_V)
              w_stateNext = LOCKED;
          end else begin
            w_expNext  = w_next;
            w_hitsNext = '0;
          end
        end
        LOCKED: begin
          if (!w_legal) begin
            w_stateNext = IDLE;
            w_hitsNext  = '0;
            w_err       = 1'b1;
            w_ill       = 1'b1;
          end else if (w_match) begin
            w_expNext = w_next;
            w_wrap    = (count_in == '0);
          end else begin
            w_stateNext = ACQ;
            w_expNext   = w_next;
            w_hitsNext  = '0;
            w_err       = 1'b1;
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_hitsNext  = '0;
        end
      endcase
    end

    if (w_err && (r_errCnt != ERR_FULL))
      w_errCntNext = r_errCnt + ERR_W'(1);
  end

  // State, tracking registers and registered pulses; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_exp    <= '0;
      r_hits   <= '0;
      r_errCnt <= '0;
      r_err    <= 1'b0;
      r_ill    <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_exp    <= w_expNext;
      r_hits   <= w_hitsNext;
      r_errCnt <= w_errCntNext;
      r_err    <= w_err;
      r_ill    <= w_ill;
      r_wrap   <= w_wrap;
    end
  end

  assign locked_o  = (r_state == LOCKED);
  assign err_o     = r_err;
  assign ill_o     = r_ill;
  assign wrap_o    = r_wrap;
  assign err_cnt_o = r_errCnt;
  assign exp_o     = r_exp;

endmodule

// File: tb/tb_mod_seq_checker.sv
// Testbench for mod_seq_checker.
// A behavioural model predicts each response into a queue, and a monitor
// compares the queued response against the DUT one cycle after each sample.
module tb_mod_seq_checker;

  localparam int LENGTH = 4;
  localparam int MAX    = 7;
  localparam int SKIP   = 3;
  localparam int LOCK_N = 3;
  localparam int ERR_W  = 2;
  localparam int ERR_SAT = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [LENGTH-1:0] count_in = '0;
  logic              count_vld = 1'b0;
  logic              locked_o, err_o, ill_o, wrap_o;
  logic [ERR_W-1:0]  err_cnt_o;
  logic [LENGTH-1:0] exp_o;

  mod_seq_checker #(
    .LENGTH(LENGTH), .MAX(MAX), .SKIP(SKIP), .LOCK_N(LOCK_N), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld),
    .locked_o(locked_o), .err_o(err_o), .ill_o(ill_o), .wrap_o(wrap_o),
    .err_cnt_o(err_cnt_o), .exp_o(exp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit err;
    bit ill;
    bit wrap;
    int errCnt;
    int expV;
  } resp_t;

  resp_t expQ[$];
  int    nVectors = 0;
  int    nMiscompares = 0;

  // Reference model: the legal sequence as a list, plus lock bookkeeping.
  int  legalList[$];
  bit  mSynced;
  bit  mLocked;
  int  mRun;
  int  mExp;
  int  mErrCnt;

  function automatic int nextOf(int v);
    for (int i = 0; i < legalList.size(); i++)
      if (legalList[i] == v) return legalList[(i + 1) % legalList.size()];
    return 0;
  endfunction

  function automatic bit isLegal(int v);
    for (int i = 0; i < legalList.size(); i++)
      if (legalList[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mSynced = 0; mLocked = 0; mRun = 0; mExp = 0; mErrCnt = 0;
  endtask

  task automatic modelStep(input bit vld, input int v, output resp_t r);
    r.err = 0; r.ill = 0; r.wrap = 0;
    if (vld) begin
      if (!isLegal(v)) begin
        r.ill = 1;
        if (mLocked) r.err = 1;
        mSynced = 0; mLocked = 0; mRun = 0;
      end else if (!mSynced) begin
        mSynced = 1; mExp = nextOf(v); mRun = 0;
      end else if (v == mExp) begin
        if (mLocked) r.wrap = (v == 0);
        else begin
          mRun++;
          if (mRun == LOCK_N) mLocked = 1;
        end
        mExp = nextOf(v);
      end else begin
        if (mLocked) r.err = 1;
        mLocked = 0; mRun = 0; mExp = nextOf(v);
      end
      if (r.err && mErrCnt < ERR_SAT) mErrCnt++;
    end
    r.locked = mLocked;
    r.errCnt = mErrCnt;
    r.expV   = mExp;
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    nVectors++;
    if (actual != required) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input bit vld, input int v);
    resp_t r;
    @(negedge clk);
    count_vld = vld;
    count_in  = LENGTH'(v);
    modelStep(vld, v, r);
    expQ.push_back(r);
  endtask

  task automatic feedSeq(input int vals[$]);
    foreach (vals[i]) applyStimulus(1'b1, vals[i]);
  endtask

  // Feed n values that the model currently expects.
  task automatic feedCorrect(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, mExp);
  endtask

  // Lock, then inject one out-of-sequence legal value.
  task automatic forceError();
    feedCorrect(LOCK_N + 1);
    applyStimulus(1'b1, nextOf(mExp));
  endtask

  resp_t monE;

  // Monitor: one registered response per sampled cycle.
  always @(posedge clk) begin
    #1;
    if (rst && expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("locked_o",  int'(locked_o),  int'(monE.locked));
      checkOutput("err_o",     int'(err_o),     int'(monE.err));
      checkOutput("ill_o",     int'(ill_o),     int'(monE.ill));
      checkOutput("wrap_o",    int'(wrap_o),    int'(monE.wrap));
      checkOutput("err_cnt_o", int'(err_cnt_o), monE.errCnt);
      checkOutput("exp_o",     int'(exp_o),     monE.expV);
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " locked_o"},  int'(locked_o),  0);
    checkOutput({tag, " err_o"},     int'(err_o),     0);
    checkOutput({tag, " ill_o"},     int'(ill_o),     0);
    checkOutput({tag, " wrap_o"},    int'(wrap_o),    0);
    checkOutput({tag, " err_cnt_o"}, int'(err_cnt_o), 0);
    checkOutput({tag, " exp_o"},     int'(exp_o),     0);
  endtask

  initial begin
    int waitCycles;
    for (int i = 0; i <= MAX; i++) if (i != SKIP) legalList.push_back(i);
    modelReset();

    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b1;

    $display("[TB] lock on 0,1,2,4");
    feedSeq('{0, 1, 2, 4});
    $display("[TB] wrap through 5,6,7,0");
    feedSeq('{5, 6, 7, 0});
    $display("[TB] sequence error and relock");
    feedSeq('{1, 2, 4, 6, 7, 0, 1});
    $display("[TB] SKIP while locked, then out-of-range in IDLE");
    feedSeq('{2, 3, 9});
    $display("[TB] valid gap while locked");
    feedSeq('{0, 1, 2, 4});
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, i * 3);
    applyStimulus(1'b1, 5);
    $display("[TB] error counter saturation");
    for (int i = 0; i < 4; i++) forceError();

    $display("[TB] reset while locked");
    feedCorrect(LOCK_N + 2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("async reset");
    modelReset();
    expQ.delete();
    count_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      bit vld;
      int v;
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) v = mExp;
      else v = $urandom_range(0, (1 << LENGTH) - 1);
      applyStimulus(vld, v);
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    checkOutput("queue drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
